// File: rtl/display_pattern_gen.sv
// Map/score stimulus generator for the whack-a-mole display path.
// Advances on a step pulse or an internal auto tick, in count, walking-one, LFSR or freeze mode.
module display_pattern_gen #(
    parameter int          HOLES     = 9,
    parameter int          SCORE_W   = 4,
    parameter int          TICK_DIV  = 25_000_000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic [1:0]         mode,
    input  logic               auto_en,
    output logic [HOLES-1:0]   map,
    output logic [SCORE_W-1:0] score,
    output logic               score_wrap
);

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_LFSR   = 2'd2,
        MODE_FREEZE = 2'd3
    } mode_e;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0]      SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam int               CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    mode_e              mode_q, mode_d;
    logic [HOLES-1:0]   map_q, map_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               wrap_q, wrap_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    mode_e              modeIn;
    logic               modeChange;
    logic               tick;
    logic               advance;
    logic               feedback;
    logic [15:0]        lfsrShift;
    logic [HOLES-1:0]   walkNext;

    assign modeIn     = mode_e'(mode);
    assign modeChange = (modeIn != mode_q);
    assign tick       = auto_en && (cnt_q == TICK_LAST);
    assign advance    = step | tick;
    assign feedback   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsrShift  = {lfsr_q[14:0], feedback};

    // A cleared map cannot rotate into a one-hot pattern, so it restarts at bit 0.
    assign walkNext = (map_q == '0) ? HOLES'(1)
                                    : ((map_q << 1) | (map_q >> (HOLES - 1)));

    always_comb begin
        mode_d  = mode_q;
        map_d   = map_q;
        score_d = score_q;
        wrap_d  = 1'b0;
        lfsr_d  = lfsr_q;

        if (modeChange || !auto_en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A mode change reloads the pattern and swallows any advance in the same cycle.
        if (modeChange) begin
            mode_d = modeIn;
            case (modeIn)
                MODE_COUNT: map_d = '0;
                MODE_WALK:  map_d = HOLES'(1);
                MODE_LFSR: begin
                    lfsr_d = SEED;
                    map_d  = SEED[HOLES-1:0];
                end
                default:    map_d = map_q;
            endcase
        end else if (advance && (mode_q != MODE_FREEZE)) begin
            score_d = score_q + SCORE_W'(1);
            wrap_d  = &score_q;
            case (mode_q)
                MODE_COUNT: map_d = map_q + HOLES'(1);
                MODE_WALK:  map_d = walkNext;
                MODE_LFSR: begin
                    lfsr_d = lfsrShift;
                    map_d  = lfsrShift[HOLES-1:0];
                end
                default:    map_d = map_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= MODE_COUNT;
            map_q   <= '0;
            score_q <= '0;
            wrap_q  <= 1'b0;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            map_q   <= map_d;
            score_q <= score_d;
            wrap_q  <= wrap_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign map        = map_q;
    assign score      = score_q;
    assign score_wrap = wrap_q;

endmodule

// File: tb/tb_display_pattern_gen.sv
// Directed bench for display_pattern_gen: count wrap, walking one, LFSR, freeze,
// auto tick with step collision, mode-switch priority and asynchronous reset.
module tb_display_pattern_gen;

    localparam int          HOLES     = 9;
    localparam int          SCORE_W   = 4;
    localparam int          TICK_DIV  = 4;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic               clk;
    logic               rst;
    logic               step;
    logic [1:0]         mode;
    logic               auto_en;
    logic [HOLES-1:0]   map;
    logic [SCORE_W-1:0] score;
    logic               score_wrap;

    int errorCount = 0;
    int checkCount = 0;
    int wrapCount  = 0;

    display_pattern_gen #(
        .HOLES     (HOLES),
        .SCORE_W   (SCORE_W),
        .TICK_DIV  (TICK_DIV),
        .LFSR_SEED (LFSR_SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step       (step),
        .mode       (mode),
        .auto_en    (auto_en),
        .map        (map),
        .score      (score),
        .score_wrap (score_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change just after a falling edge, so the next rising edge samples them
    // and the outputs are read back at the following falling edge.
    task automatic applyStimulus(input logic s, input logic [1:0] m, input logic a);
        step    = s;
        mode    = m;
        auto_en = a;
        @(negedge clk);
    endtask

    logic [HOLES-1:0] walkTable [9];

    initial begin
        walkTable = '{9'h002, 9'h004, 9'h008, 9'h010, 9'h020,
                      9'h040, 9'h080, 9'h100, 9'h001};

        rst     = 1'b0;
        step    = 1'b0;
        mode    = 2'd0;
        auto_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_map", 32'(map), 32'h0);
        checkOutput("reset_score", 32'(score), 32'h0);
        checkOutput("reset_wrap", 32'(score_wrap), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle_map", 32'(map), 32'h0);

        // Count mode: step held high for 512 cycles covers a full map wrap and 32 score wraps.
        for (int i = 1; i <= 512; i++) begin
            applyStimulus(1'b1, 2'd0, 1'b0);
            checkOutput("count_map", 32'(map), 32'(i % 512));
            checkOutput("count_score", 32'(score), 32'(i % 16));
            checkOutput("count_wrap", 32'(score_wrap), 32'((i % 16) == 0));
            if (score_wrap) wrapCount++;
        end
        checkOutput("count_wrap_total", 32'(wrapCount), 32'd32);

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd0, 1'b0);
        checkOutput("pre_switch_map", 32'(map), 32'h005);
        checkOutput("pre_switch_score", 32'(score), 32'd5);

        applyStimulus(1'b1, 2'd1, 1'b0);
        checkOutput("switch_prio_map", 32'(map), 32'h001);
        checkOutput("switch_prio_score", 32'(score), 32'd5);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 2'd1, 1'b0);
            checkOutput("walk_map", 32'(map), 32'(walkTable[i]));
        end
        checkOutput("walk_score", 32'(score), 32'd14);

        applyStimulus(1'b0, 2'd2, 1'b0);
        checkOutput("lfsr_load_map", 32'(map), 32'h0E1);
        checkOutput("lfsr_load_score", 32'(score), 32'd14);
        applyStimulus(1'b1, 2'd2, 1'b0);
        checkOutput("lfsr_step1_map", 32'(map), 32'h1C3);
        checkOutput("lfsr_step1_score", 32'(score), 32'd15);
        checkOutput("lfsr_step1_wrap", 32'(score_wrap), 32'h0);
        applyStimulus(1'b1, 2'd2, 1'b0);
        checkOutput("lfsr_step2_map", 32'(map), 32'h187);
        checkOutput("lfsr_step2_score", 32'(score), 32'd0);
        checkOutput("lfsr_step2_wrap", 32'(score_wrap), 32'h1);
        applyStimulus(1'b0, 2'd2, 1'b0);
        checkOutput("lfsr_hold_map", 32'(map), 32'h187);
        checkOutput("wrap_one_cycle", 32'(score_wrap), 32'h0);

        applyStimulus(1'b0, 2'd3, 1'b1);
        checkOutput("freeze_load_map", 32'(map), 32'h187);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'(i % 2), 2'd3, 1'b1);
            checkOutput("freeze_map", 32'(map), 32'h187);
            checkOutput("freeze_score", 32'(score), 32'd0);
            checkOutput("freeze_wrap", 32'(score_wrap), 32'h0);
        end

        // Auto tick: the mode-change edge clears the counter, then one advance every 4 edges.
        applyStimulus(1'b0, 2'd0, 1'b1);
        checkOutput("auto_load_map", 32'(map), 32'h0);
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(1'b0, 2'd0, 1'b1);
            checkOutput("auto_map", 32'(map), 32'(k / 4));
            checkOutput("auto_score", 32'(score), 32'(k / 4));
        end
        applyStimulus(1'b1, 2'd0, 1'b1);
        checkOutput("collide_map", 32'(map), 32'd4);
        checkOutput("collide_score", 32'(score), 32'd4);
        for (int k = 17; k <= 20; k++) begin
            applyStimulus(1'b0, 2'd0, 1'b1);
            checkOutput("post_collide_map", 32'(map), 32'(k / 4));
            checkOutput("post_collide_score", 32'(score), 32'(k / 4));
        end

        for (int i = 0; i < 158; i++) applyStimulus(1'b1, 2'd0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0);
        checkOutput("pre_reset_map", 32'(map), 32'h0A3);
        checkOutput("pre_reset_score", 32'(score), 32'd3);

        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_reset_map", 32'(map), 32'h0);
        checkOutput("async_reset_score", 32'(score), 32'h0);
        checkOutput("async_reset_wrap", 32'(score_wrap), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 2'd0, 1'b0);
        checkOutput("post_reset_map", 32'(map), 32'h001);
        checkOutput("post_reset_score", 32'(score), 32'd1);
        applyStimulus(1'b0, 2'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
